mips_multicycle_control: RTL

Multi-cycle sequencer for the team MIPS CPU. Steps each instruction through fetch, decode, execute, memory and writeback states, and drives the register file write port, PC update, memory handshake and datapath muxes. Sits between the Avalon-style memory bus and the datapath that contains the register file and ALU. Holds the only copy of the current instruction (IR).

---
 rtl/mips_pkg.sv | 32 +++
 rtl/mips_decoder.sv | 22 ++
 rtl/mips_multicycle_control.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control slice.
// Optional illegal-opcode trapping is enabled by ILLEGAL_OP_TRAP_EN.
package mips_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALTED = 3'd6
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_JR   = 6'h08;

    typedef enum logic [2:0] {
        ALU_R   = 3'd0,
        ALU_I   = 3'd1,
        LOAD    = 3'd2,
        STORE   = 3'd3,
        JUMPREG = 3'd4,
        ILLEGAL = 3'd5
    } instr_class_t;

endpackage

// File: rtl/mips_decoder.sv
// Classifies the latched instruction from its opcode and funct fields.
module mips_decoder
    import mips_pkg::*;
(
    input  logic [5:0]   op_i,
    input  logic [5:0]   funct_i,
    output instr_class_t cls_o
);

    always_comb begin
        cls_o = ILLEGAL;
        unique case (1'b1)
            (op_i == OP_SPECIAL && funct_i == FN_ADDU): cls_o = ALU_R;
            (op_i == OP_SPECIAL && funct_i == FN_JR):   cls_o = JUMPREG;
            (op_i == OP_ADDIU):                         cls_o = ALU_I;
            (op_i == OP_LW):                            cls_o = LOAD;
            (op_i == OP_SW):                            cls_o = STORE;
            default:                                    cls_o = ILLEGAL;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle sequencer: FETCH/DECODE/EXEC/MEM/WB with Moore strobes.
// Define ILLEGAL_OP_TRAP_EN to halt with error on unsupported instructions.
module mips_multicycle_control
    import mips_pkg::*;
#(
    parameter int RESET_STALL = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    input  logic        rs_is_zero,
    output logic        mem_read,
    output logic        mem_write,
    output logic        addr_sel,
    output logic [31:0] ir,
    output logic        pc_write,
    output logic        pc_src,
    output logic        alu_src_b,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        reg_write_enable,
    output logic        active,
    output logic        error
);

    localparam logic [3:0] STALL = 4'(RESET_STALL);

    state_t       state_q, state_d;
    logic [31:0]  ir_q, ir_d;
    logic [3:0]   stall_q, stall_d;
    instr_class_t cls;

    mips_decoder u_decoder (
        .op_i    (ir_q[31:26]),
        .funct_i (ir_q[5:0]),
        .cls_o   (cls)
    );

`ifdef ILLEGAL_OP_TRAP_EN
    logic err_q, err_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            stall_q <= stall_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        stall_d = stall_q;
`ifdef ILLEGAL_OP_TRAP_EN
        err_d   = err_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (stall_q == STALL) state_d = S_FETCH;
                else                  stall_d = stall_q + 4'd1;
            end
            S_FETCH: begin
                if (!mem_waitrequest) begin
                    ir_d    = mem_readdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                unique case (cls)
                    ALU_R, ALU_I: state_d = S_WB;
                    LOAD, STORE:  state_d = S_MEM;
                    JUMPREG:      state_d = rs_is_zero ? S_HALTED : S_FETCH;
                    default: begin
`ifdef ILLEGAL_OP_TRAP_EN
                        state_d = S_HALTED;
                        err_d   = 1'b1;
`else
                        state_d = S_FETCH;
`endif
                    end
                endcase
            end
            S_MEM: begin
                if (!mem_waitrequest)
                    state_d = (cls == LOAD) ? S_WB : S_FETCH;
            end
            S_WB:     state_d = S_FETCH;
            S_HALTED: state_d = S_HALTED;
            default:  state_d = S_IDLE;
        endcase
    end

    // Strobes follow state and IR; only FETCH's pc_write sees waitrequest.
    always_comb begin
        mem_read         = 1'b0;
        mem_write        = 1'b0;
        addr_sel         = 1'b0;
        pc_write         = 1'b0;
        pc_src           = 1'b0;
        alu_src_b        = 1'b0;
        reg_dst          = 1'b0;
        mem_to_reg       = 1'b0;
        reg_write_enable = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                mem_read = 1'b1;
                pc_write = !mem_waitrequest;
            end
            S_EXEC: begin
                alu_src_b = cls inside {ALU_I, LOAD, STORE};
                if (cls == JUMPREG && !rs_is_zero) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
            end
            S_MEM: begin
                addr_sel  = 1'b1;
                mem_read  = (cls == LOAD);
                mem_write = (cls == STORE);
            end
            S_WB: begin
                reg_write_enable = 1'b1;
                reg_dst          = (cls == ALU_R);
                mem_to_reg       = (cls == LOAD);
            end
            default: ;
        endcase
    end

    assign ir     = ir_q;
    assign active = (state_q != S_HALTED);

endmodule
